// File: rtl/lc3_multicycle_controller.sv
// LC-3 multicycle control unit.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It issues memory
// requests with a bounded wait, derives the datapath strobes and mux selects,
// and latches the instruction register and condition codes.
// HALT and ERR are absorbing states that only rst can leave.
// After reset the unit spends one quiet cycle in FETCH. During that cycle
// every strobe and mem_req are low and mem_ready is ignored.
module lc3_multicycle_controller #(
    parameter int         DATA_W      = 16,
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [7:0] HALT_VEC    = 8'h25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        addr_sel,
    output logic [DATA_W-1:0] ir,
    output logic              ir_load,
    output logic              pc_load,
    output logic              RegWrite,
    output logic              cc_load,
    output logic              ptr_load,
    output logic [1:0]        pc_sel,
    output logic [1:0]        wb_sel,
    output logic [1:0]        ALUControl,
    output logic [1:0]        ExtByHowMuch,
    output logic              dr_r7,
    output logic [2:0]        nzp,
    output logic [2:0]        state,
    output logic              halted,
    output logic              error
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSV  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // One spare bit so the counter can hold MEM_TIMEOUT without wrapping.
    localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    // Condition codes: negative, zero or positive.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1]) begin
            return 3'b100;
        end else if (v == {DATA_W{1'b0}}) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    state_t              state_r, next_s;
    logic [DATA_W-1:0]   ir_r;
    logic [2:0]          nzp_r;
    logic [CNT_W-1:0]    wait_cnt_r, wait_next_s;
    logic                ind_phase_r, ind_next_s;
    logic                idle_r;
    logic                halted_r, error_r;

    logic                mem_req_s, mem_we_s, ir_load_s, pc_load_s;
    logic                reg_write_s, cc_load_s, ptr_load_s, dr_r7_s;
    logic [1:0]          addr_sel_s, pc_sel_s, wb_sel_s;
    logic [1:0]          alu_ctrl_s, ext_s;

    logic [3:0]          opcode_s;
    logic                is_load_s, is_store_s, is_ind_s, br_take_s, timeout_s;

    assign opcode_s   = ir_r[DATA_W-1 -: 4];
    assign is_load_s  = (opcode_s == OP_LD) || (opcode_s == OP_LDR) || (opcode_s == OP_LDI);
    assign is_store_s = (opcode_s == OP_ST) || (opcode_s == OP_STR) || (opcode_s == OP_STI);
    assign is_ind_s   = (opcode_s == OP_LDI) || (opcode_s == OP_STI);
    assign br_take_s  = (ir_r[11:9] & nzp_r) != 3'b000;
    assign timeout_s  = (wait_cnt_r >= CNT_LIMIT);

    // Datapath decode of the latched instruction (ALU op and offset width).
    always_comb begin
        alu_ctrl_s = 2'b00;
        ext_s      = 2'b10;
        case (opcode_s)
            OP_AND:  begin alu_ctrl_s = 2'b01; ext_s = 2'b00; end
            OP_NOT:  begin alu_ctrl_s = 2'b10; ext_s = 2'b00; end
            OP_ADD:  begin alu_ctrl_s = 2'b00; ext_s = 2'b00; end
            OP_JSR:  begin alu_ctrl_s = 2'b00; ext_s = 2'b11; end
            OP_LDR,
            OP_STR:  begin alu_ctrl_s = 2'b00; ext_s = 2'b01; end
            default: begin alu_ctrl_s = 2'b00; ext_s = 2'b10; end
        endcase
    end

    // Next-state, strobe and select generation.
    always_comb begin
        next_s      = state_r;
        ind_next_s  = 1'b0;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        addr_sel_s  = 2'd0;
        ir_load_s   = 1'b0;
        pc_load_s   = 1'b0;
        reg_write_s = 1'b0;
        cc_load_s   = 1'b0;
        ptr_load_s  = 1'b0;
        pc_sel_s    = 2'd0;
        wb_sel_s    = 2'd0;
        dr_r7_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (idle_r) begin
                    next_s = S_FETCH;
                end else begin
                    mem_req_s = 1'b1;
                    if (mem_ready) begin
                        ir_load_s = 1'b1;
                        pc_load_s = 1'b1;
                        next_s    = S_DECODE;
                    end else if (timeout_s) begin
                        next_s = S_ERR;
                    end else begin
                        next_s = S_FETCH;
                    end
                end
            end
            S_DECODE: begin
                if ((opcode_s == OP_RSV) || (opcode_s == OP_RTI)) begin
                    next_s = S_ERR;
                end else if ((opcode_s == OP_TRAP) && (ir_r[7:0] == HALT_VEC)) begin
                    next_s = S_HALT;
                end else begin
                    next_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode_s)
                    OP_ADD, OP_AND, OP_NOT: begin
                        reg_write_s = 1'b1;
                        cc_load_s   = 1'b1;
                        next_s      = S_FETCH;
                    end
                    OP_LEA: begin
                        reg_write_s = 1'b1;
                        cc_load_s   = 1'b1;
                        wb_sel_s    = 2'd3;
                        next_s      = S_FETCH;
                    end
                    OP_BR: begin
                        if (br_take_s) begin
                            pc_load_s = 1'b1;
                            pc_sel_s  = 2'd1;
                        end else begin
                            pc_load_s = 1'b0;
                        end
                        next_s = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load_s = 1'b1;
                        pc_sel_s  = 2'd2;
                        next_s    = S_FETCH;
                    end
                    OP_JSR: begin
                        reg_write_s = 1'b1;
                        dr_r7_s     = 1'b1;
                        wb_sel_s    = 2'd2;
                        pc_load_s   = 1'b1;
                        pc_sel_s    = ir_r[11] ? 2'd1 : 2'd2;
                        next_s      = S_FETCH;
                    end
                    OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: begin
                        next_s = S_MEM;
                    end
                    OP_TRAP: begin
                        reg_write_s = 1'b1;
                        dr_r7_s     = 1'b1;
                        wb_sel_s    = 2'd2;
                        next_s      = S_MEM;
                    end
                    default: begin
                        next_s = S_ERR;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = (is_ind_s && ind_phase_r) ? 2'd2 : 2'd1;
                if (is_store_s && !(is_ind_s && !ind_phase_r)) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (mem_ready) begin
                    if (is_ind_s && !ind_phase_r) begin
                        ptr_load_s = 1'b1;
                        ind_next_s = 1'b1;
                        next_s     = S_MEM;
                    end else if (opcode_s == OP_TRAP) begin
                        pc_load_s = 1'b1;
                        pc_sel_s  = 2'd3;
                        next_s    = S_FETCH;
                    end else if (is_store_s) begin
                        next_s = S_FETCH;
                    end else if (is_load_s) begin
                        next_s = S_WB;
                    end else begin
                        next_s = S_ERR;
                    end
                end else if (timeout_s) begin
                    next_s = S_ERR;
                end else begin
                    ind_next_s = ind_phase_r;
                    next_s     = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s = 1'b1;
                cc_load_s   = 1'b1;
                wb_sel_s    = 2'd1;
                next_s      = S_FETCH;
            end
            S_HALT: begin
                next_s = S_HALT;
            end
            S_ERR: begin
                next_s = S_ERR;
            end
            default: begin
                next_s = S_ERR;
            end
        endcase
    end

    // Wait counter restarts whenever the unit is not waiting on memory.
    always_comb begin
        if (((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready && !idle_r) begin
            wait_next_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_next_s = CNT_ZERO;
        end
    end

    // State, instruction, condition-code and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_FETCH;
            ir_r        <= {DATA_W{1'b0}};
            nzp_r       <= 3'b010;
            wait_cnt_r  <= CNT_ZERO;
            ind_phase_r <= 1'b0;
            idle_r      <= 1'b1;
            halted_r    <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= next_s;
            ir_r        <= ir_load_s ? mem_data : ir_r;
            nzp_r       <= cc_load_s ? nzp_of(result) : nzp_r;
            wait_cnt_r  <= wait_next_s;
            ind_phase_r <= ind_next_s;
            idle_r      <= 1'b0;
            halted_r    <= (next_s == S_HALT);
            error_r     <= (next_s == S_ERR);
        end
    end

    assign mem_req      = mem_req_s;
    assign mem_we       = mem_we_s;
    assign addr_sel     = addr_sel_s;
    assign ir           = ir_r;
    assign ir_load      = ir_load_s;
    assign pc_load      = pc_load_s;
    assign RegWrite     = reg_write_s;
    assign cc_load      = cc_load_s;
    assign ptr_load     = ptr_load_s;
    assign pc_sel       = pc_sel_s;
    assign wb_sel       = wb_sel_s;
    assign ALUControl   = alu_ctrl_s;
    assign ExtByHowMuch = ext_s;
    assign dr_r7        = dr_r7_s;
    assign nzp          = nzp_r;
    assign state        = state_r;
    assign halted       = halted_r;
    assign error        = error_r;

endmodule

// File: tb/tb_lc3_multicycle_controller.sv
// Directed bench for lc3_multicycle_controller.
// The stimulus process drives one cycle at a time and queues the expected
// outputs for that cycle. The monitor pops the queue on the falling edge and
// compares against the live outputs.
module tb_lc3_multicycle_controller;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5, R = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] md  = 16'h0000;
    logic        mr  = 1'b0;
    logic [15:0] res = 16'h0000;

    logic        mem_req, mem_we, ir_load, pc_load, RegWrite, cc_load, ptr_load, dr_r7, halted, error;
    logic [1:0]  addr_sel, pc_sel, wb_sel, ALUControl, ExtByHowMuch;
    logic [15:0] ir;
    logic [2:0]  nzp, state;

    lc3_multicycle_controller dut (
        .clk(clk), .rst(rst), .mem_data(md), .mem_ready(mr), .result(res),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir),
        .ir_load(ir_load), .pc_load(pc_load), .RegWrite(RegWrite), .cc_load(cc_load),
        .ptr_load(ptr_load), .pc_sel(pc_sel), .wb_sel(wb_sel), .ALUControl(ALUControl),
        .ExtByHowMuch(ExtByHowMuch), .dr_r7(dr_r7), .nzp(nzp), .state(state),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [21:0] ctl;
        bit          has_dec;
        logic [15:0] dir;
        logic [1:0]  alu;
        logic [1:0]  ext;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    bit          dec_pend = 1'b0;
    logic [15:0] dec_ir   = 16'h0000;
    logic [1:0]  dec_alu  = 2'b00;
    logic [1:0]  dec_ext  = 2'b00;

    // Field order: state, mem_req, mem_we, addr_sel, {ir_load,pc_load,RegWrite,cc_load,ptr_load}, pc_sel, wb_sel, dr_r7, nzp, halted, error
    function automatic logic [21:0] pk(input logic [2:0] st, input logic rq, input logic we,
                                       input logic [1:0] as, input logic [4:0] sb,
                                       input logic [1:0] ps, input logic [1:0] ws,
                                       input logic r7, input logic [2:0] nz,
                                       input logic h, input logic e);
        return {st, rq, we, as, sb, ps, ws, r7, nz, h, e};
    endfunction

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic chk(input string nm, input logic [2:0] st, input logic rq, input logic we,
                       input logic [1:0] as, input logic [4:0] sb, input logic [1:0] ps,
                       input logic [1:0] ws, input logic r7, input logic [2:0] nz);
        exp_t x;
        x.nm      = nm;
        x.ctl     = pk(st, rq, we, as, sb, ps, ws, r7, nz, st == H, st == R);
        x.has_dec = dec_pend;
        x.dir     = dec_ir;
        x.alu     = dec_alu;
        x.ext     = dec_ext;
        dec_pend  = 1'b0;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string nm, input logic [2:0] st, input logic [2:0] nz);
        chk(nm, st, 1'b0, 1'b0, 2'd0, 5'b00000, 2'd0, 2'd0, 1'b0, nz);
    endtask

    task automatic setdec(input logic [15:0] i, input logic [1:0] a, input logic [1:0] x);
        dec_pend = 1'b1;
        dec_ir   = i;
        dec_alu  = a;
        dec_ext  = x;
    endtask

    task automatic fetch_ok(input string nm, input logic [15:0] instr, input logic [2:0] nz);
        md = instr;
        mr = 1'b1;
        chk(nm, F, 1'b1, 1'b0, 2'd0, 5'b11000, 2'd0, 2'd0, 1'b0, nz);
        mr = 1'b0;
    endtask

    // mem_ready is raised during DECODE to show it has no effect there.
    task automatic decode(input string nm, input logic [15:0] instr, input logic [1:0] a,
                          input logic [1:0] x, input logic [2:0] nz);
        setdec(instr, a, x);
        mr = 1'b1;
        chk0(nm, D, nz);
        mr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mr  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        setdec(16'h0000, 2'b00, 2'b10);
        chk0("rst_idle", F, 3'b010);
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [21:0] act;
            x   = exp_q.pop_front();
            act = pk(state, mem_req, mem_we, addr_sel,
                     {ir_load, pc_load, RegWrite, cc_load, ptr_load},
                     pc_sel, wb_sel, dr_r7, nzp, halted, error);
            total_cnt++;
            if (act === x.ctl) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: ctl got %b want %b", x.nm, act, x.ctl);
            end
            if (x.has_dec) begin
                total_cnt++;
                if ({ir, ALUControl, ExtByHowMuch} === {x.dir, x.alu, x.ext}) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s_dec: ir/alu/ext got %h/%b/%b want %h/%b/%b",
                             x.nm, ir, ALUControl, ExtByHowMuch, x.dir, x.alu, x.ext);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        setdec(16'h0000, 2'b00, 2'b10);
        chk0("rst_idle0", F, 3'b010);

        // ADD R1,R2,#-1 with a negative result
        fetch_ok("add_f", 16'h12BF, 3'b010);
        decode("add_d", 16'h12BF, 2'b00, 2'b00, 3'b010);
        res = 16'hFFFF;
        chk("add_e", E, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd0, 1'b0, 3'b010);

        // AND R1,R1,#0 -> zero
        fetch_ok("and_f", 16'h5260, 3'b100);
        decode("and_d", 16'h5260, 2'b01, 2'b00, 3'b100);
        res = 16'h0000;
        chk("and_e", E, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd0, 1'b0, 3'b100);

        // BRz taken with nzp=010
        fetch_ok("brz_f", 16'h0403, 3'b010);
        decode("brz_d", 16'h0403, 2'b00, 2'b10, 3'b010);
        chk("brz_take", E, 1'b0, 1'b0, 2'd0, 5'b01000, 2'd1, 2'd0, 1'b0, 3'b010);

        // NOT -> positive
        fetch_ok("not_f", 16'h927F, 3'b010);
        decode("not_d", 16'h927F, 2'b10, 2'b00, 3'b010);
        res = 16'h0001;
        chk("not_e", E, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd0, 1'b0, 3'b010);

        // BRz not taken with nzp=001
        fetch_ok("brz2_f", 16'h0403, 3'b001);
        decode("brz2_d", 16'h0403, 2'b00, 2'b10, 3'b001);
        chk0("brz_not", E, 3'b001);

        // LEA writes the effective address
        fetch_ok("lea_f", 16'hE205, 3'b001);
        decode("lea_d", 16'hE205, 2'b00, 2'b10, 3'b001);
        res = 16'h8000;
        chk("lea_e", E, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd3, 1'b0, 3'b001);

        // JMP, JSR, JSRR
        fetch_ok("jmp_f", 16'hC080, 3'b100);
        decode("jmp_d", 16'hC080, 2'b00, 2'b10, 3'b100);
        chk("jmp_e", E, 1'b0, 1'b0, 2'd0, 5'b01000, 2'd2, 2'd0, 1'b0, 3'b100);
        fetch_ok("jsr_f", 16'h4801, 3'b100);
        decode("jsr_d", 16'h4801, 2'b00, 2'b11, 3'b100);
        chk("jsr_e", E, 1'b0, 1'b0, 2'd0, 5'b01100, 2'd1, 2'd2, 1'b1, 3'b100);
        fetch_ok("jsrr_f", 16'h4080, 3'b100);
        decode("jsrr_d", 16'h4080, 2'b00, 2'b11, 3'b100);
        chk("jsrr_e", E, 1'b0, 1'b0, 2'd0, 5'b01100, 2'd2, 2'd2, 1'b1, 3'b100);

        // LDI: each memory access is ready on its third cycle, 10 cycles in total
        fetch_ok("ldi_f", 16'hA201, 3'b100);
        decode("ldi_d", 16'hA201, 2'b00, 2'b10, 3'b100);
        chk0("ldi_e", E, 3'b100);
        chk("ldi_m1a", M, 1'b1, 1'b0, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b100);
        chk("ldi_m1b", M, 1'b1, 1'b0, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b100);
        mr = 1'b1;
        chk("ldi_m1c", M, 1'b1, 1'b0, 2'd1, 5'b00001, 2'd0, 2'd0, 1'b0, 3'b100);
        mr = 1'b0;
        chk("ldi_m2a", M, 1'b1, 1'b0, 2'd2, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b100);
        chk("ldi_m2b", M, 1'b1, 1'b0, 2'd2, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b100);
        mr = 1'b1;
        chk("ldi_m2c", M, 1'b1, 1'b0, 2'd2, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b100);
        mr = 1'b0;
        res = 16'h0000;
        chk("ldi_wb", W, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd1, 1'b0, 3'b100);

        // STR zero-wait: 4 cycles
        fetch_ok("str_f", 16'h7240, 3'b010);
        decode("str_d", 16'h7240, 2'b00, 2'b01, 3'b010);
        chk0("str_e", E, 3'b010);
        mr = 1'b1;
        chk("str_m", M, 1'b1, 1'b1, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b010);

        // LD zero-wait: 5 cycles
        fetch_ok("ld_f", 16'h2205, 3'b010);
        decode("ld_d", 16'h2205, 2'b00, 2'b10, 3'b010);
        chk0("ld_e", E, 3'b010);
        mr = 1'b1;
        chk("ld_m", M, 1'b1, 1'b0, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b010);
        mr = 1'b0;
        res = 16'h0001;
        chk("ld_wb", W, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd1, 1'b0, 3'b010);

        // STI zero-wait: pointer read, then write
        fetch_ok("sti_f", 16'hB201, 3'b001);
        decode("sti_d", 16'hB201, 2'b00, 2'b10, 3'b001);
        chk0("sti_e", E, 3'b001);
        mr = 1'b1;
        chk("sti_m1", M, 1'b1, 1'b0, 2'd1, 5'b00001, 2'd0, 2'd0, 1'b0, 3'b001);
        chk("sti_m2", M, 1'b1, 1'b1, 2'd2, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b001);

        // TRAP x23: link R7, read the vector, jump
        fetch_ok("trap_f", 16'hF023, 3'b001);
        decode("trap_d", 16'hF023, 2'b00, 2'b10, 3'b001);
        chk("trap_e", E, 1'b0, 1'b0, 2'd0, 5'b00100, 2'd0, 2'd2, 1'b1, 3'b001);
        chk("trap_mw", M, 1'b1, 1'b0, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b001);
        mr = 1'b1;
        chk("trap_m", M, 1'b1, 1'b0, 2'd1, 5'b01000, 2'd3, 2'd0, 1'b0, 3'b001);
        mr = 1'b0;

        // FETCH ready on exactly cycle 15 is accepted
        md = 16'h1000;
        for (int i = 0; i < 14; i++) begin
            chk("fto_wait", F, 1'b1, 1'b0, 2'd0, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b001);
        end
        fetch_ok("fto_ok", 16'h1000, 3'b001);
        decode("fto_d", 16'h1000, 2'b00, 2'b00, 3'b001);
        res = 16'h0001;
        chk("fto_e", E, 1'b0, 1'b0, 2'd0, 5'b00110, 2'd0, 2'd0, 1'b0, 3'b001);

        // Reserved opcode and RTI both end in ERR
        fetch_ok("rsv_f", 16'hD000, 3'b001);
        decode("rsv_d", 16'hD000, 2'b00, 2'b10, 3'b001);
        mr = 1'b1;
        chk0("rsv_err1", R, 3'b001);
        chk0("rsv_err2", R, 3'b001);
        do_reset();
        fetch_ok("rti_f", 16'h8000, 3'b010);
        decode("rti_d", 16'h8000, 2'b00, 2'b10, 3'b010);
        chk0("rti_err", R, 3'b010);
        do_reset();

        // FETCH with no mem_ready for 16 cycles -> ERR, sticky
        md = 16'h1000;
        for (int i = 0; i < 16; i++) begin
            chk("fto_fail", F, 1'b1, 1'b0, 2'd0, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b010);
        end
        for (int i = 0; i < 3; i++) begin
            mr = i[0];
            chk0("fto_err", R, 3'b010);
        end
        do_reset();

        // MEM timeout during LD
        fetch_ok("mto_f", 16'h2205, 3'b010);
        decode("mto_d", 16'h2205, 2'b00, 2'b10, 3'b010);
        chk0("mto_e", E, 3'b010);
        for (int i = 0; i < 16; i++) begin
            chk("mto_wait", M, 1'b1, 1'b0, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b010);
        end
        chk0("mto_err", R, 3'b010);
        do_reset();

        // TRAP x25 halts and stays halted
        fetch_ok("halt_f", 16'hF025, 3'b010);
        decode("halt_d", 16'hF025, 2'b00, 2'b10, 3'b010);
        for (int i = 0; i < 20; i++) begin
            mr = i[0];
            chk0("halt_hold", H, 3'b010);
        end
        do_reset();

        // Reset in the middle of an STR write
        fetch_ok("rstr_f", 16'h7240, 3'b010);
        decode("rstr_d", 16'h7240, 2'b00, 2'b01, 3'b010);
        chk0("rstr_e", E, 3'b010);
        rst = 1'b1;
        mr  = 1'b0;
        chk("rstr_m", M, 1'b1, 1'b1, 2'd1, 5'b00000, 2'd0, 2'd0, 1'b0, 3'b010);
        rst = 1'b0;
        setdec(16'h0000, 2'b00, 2'b10);
        chk0("rstr_after", F, 3'b010);

        @(negedge clk);
        #1;
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
